// File: rtl/uart_echo_engine.sv
// Byte-processing core between uart_rx and uart_tx: FIFO buffering, runtime-selected
// transform, one uart_tx transfer per byte, overflow accounting and status LEDs.
module uart_echo_engine #(
   parameter int unsigned DEPTH        = 16,
   parameter logic [7:0]  OFFSET       = 8'd1,
   parameter bit          DROP_ON_FULL = 1'b1,
   parameter int unsigned HB_CYCLES    = 50_000_000
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     rx_en,
   input  logic                     tx_busy,
   output logic                     tx_en,
   output logic [7:0]               tx_data,
   input  logic [1:0]               mode,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              overflow_cnt,
   output logic [3:0]               led
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam int unsigned HBW = $clog2(HB_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   logic [7:0]     r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [LW-1:0]  r_level;
   logic [7:0]     r_q;
   state_t         r_state;
   logic           r_tx_en;
   logic [7:0]     r_tx_data;
   logic [15:0]    r_ovf_cnt;
   logic [HBW-1:0] r_hb_cnt;
   logic           r_hb_led;
   logic           r_ne_led;
   logic           r_ovf_led;
   logic           r_busy_led;

   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_write;
   logic w_drop;

   function automatic logic [7:0] f_xform(input logic [7:0] q, input logic [1:0] m);
      logic [7:0] res;
      res = q;
      case (m)
         2'd1: res = q + OFFSET;
         2'd2: begin
            if (q >= 8'h41 && q <= 8'h5A)      res = q + 8'd32;
            else if (q >= 8'h61 && q <= 8'h7A) res = q - 8'd32;
         end
         2'd3: if (q >= 8'h61 && q <= 8'h7A) res = q - 8'd32;
         default: res = q;
      endcase
      return res;
   endfunction

   assign w_full  = (r_level == LW'(DEPTH));
   assign rx_en   = DROP_ON_FULL ? 1'b1 : !w_full;
   assign w_pop   = (r_state == S_IDLE) && (r_level != '0) && !tx_busy;
   assign w_push  = rx_valid && rx_en;
   // A push while full is still accepted if the same cycle frees a slot.
   assign w_write = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   // Storage and synchronous read port; no reset needed on the array.
   always_ff @(posedge clk_in) begin
      if (w_write) r_mem[r_wr_ptr] <= rx_data;
      if (w_pop)   r_q <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_state    <= S_IDLE;
         r_tx_en    <= 1'b0;
         r_tx_data  <= '0;
         r_ovf_cnt  <= '0;
         r_hb_cnt   <= '0;
         r_hb_led   <= 1'b0;
         r_ne_led   <= 1'b0;
         r_ovf_led  <= 1'b0;
         r_busy_led <= 1'b0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);

         if (w_write && !w_pop)      r_level <= r_level + LW'(1);
         else if (!w_write && w_pop) r_level <= r_level - LW'(1);

         if (w_drop) begin
            r_ovf_led <= 1'b1;
            if (r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
         end

         if (r_hb_cnt == HBW'(HB_CYCLES - 1)) begin
            r_hb_cnt <= '0;
            r_hb_led <= !r_hb_led;
         end else begin
            r_hb_cnt <= r_hb_cnt + HBW'(1);
         end

         r_ne_led   <= (r_level != '0);
         r_busy_led <= (r_state != S_IDLE);

         r_tx_en <= 1'b0;
         case (r_state)
            S_IDLE:    if (w_pop) r_state <= S_FETCH;
            S_FETCH: begin
               r_tx_data <= f_xform(r_q, mode);
               r_tx_en   <= 1'b1;
               r_state   <= S_SEND;
            end
            S_SEND:    r_state <= S_WAIT_HI;
            S_WAIT_HI: if (tx_busy) r_state <= S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_en        = r_tx_en;
   assign tx_data      = r_tx_data;
   assign fifo_level   = r_level;
   assign overflow_cnt = r_ovf_cnt;
   assign led          = {r_busy_led, r_ovf_led, r_ne_led, r_hb_led};

endmodule
